data_memory: RTL
================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the number of 32-bit words (power of two, 4..16384).
REQ-002 SHALL have parameter CLEAR_ON_RESET, default 1, meaning zero-fill the array after reset (1) or skip the fill (0).
REQ-003 SHALL have port Clock, input, 1, the single clock; all state changes on posedge.
REQ-004 SHALL have port nReset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port Address, input, 16, byte address from the processor.
REQ-006 SHALL have port ReadEn, input, 1, load request.
REQ-007 SHALL have port WriteEn, input, 1, full-word store request.
REQ-008 SHALL have port WriteL, input, 1, store-word-left (SWL) request.
REQ-009 SHALL have port WriteR, input, 1, store-word-right (SWR) request.
REQ-010 SHALL have port WriteData, input, 32, store data (rt value).
REQ-011 SHALL have port ReadData, output, 32, load data.
REQ-012 SHALL have port Ready, output, 1, high when requests are accepted.
REQ-013 SHALL have port AccessErr, output, 1, one-cycle pulse on a conflicting store request.

Function
REQ-014 SHALL form the word index as Address[log2(DEPTH)+1:2] and ignore the higher bits (wrap-around); Address[1:0] = byte offset b.
REQ-015 SHALL sample requests only on a posedge where Ready=1; requests with Ready=0 are dropped with no side effects.
REQ-016 SHALL apply a WriteEn store to the whole word at that posedge.
REQ-017 SHALL use big-endian byte order for SWL at offset b: mask = FFFFFFFF>>(8b), written data = WriteData>>(8b), masked bits only.
REQ-018 SHALL, for SWR at offset b, use mask = FFFFFFFF<<(8(3-b)) and written data = WriteData<<(8(3-b)).
REQ-019 SHALL ignore Address[1:0] for WriteEn and ReadEn (word-aligned access).
REQ-020 SHALL resolve multiple store strobes by priority WriteEn > WriteL > WriteR, and pulse AccessErr for one cycle when more than one strobe is high.
REQ-021 SHALL register ReadData one cycle after an accepted ReadEn and hold it until the next accepted read.
REQ-022 SHALL, when ReadEn and a store target the same word in the same cycle, return the post-merge word (write-first).
REQ-023 SHALL return newly written data for a store at cycle N followed by a read at N+1.
REQ-024 SHALL implement states CLEAR and RUN: after reset, CLEAR when CLEAR_ON_RESET=1, otherwise RUN.
REQ-025 SHALL, in CLEAR, write zero to one word per cycle with index counter 0..DEPTH-1, hold Ready=0, and enter RUN after word DEPTH-1 is written (DEPTH cycles).
REQ-026 SHALL hold Ready=1 in RUN; RUN SHALL be exited only by reset.

Reset
REQ-027 SHALL drive ReadData=0, Ready=0, AccessErr=0 and the clear counter=0 while nReset=0, independent of Clock.
REQ-028 SHALL, on reset asserted mid-CLEAR or mid-RUN, abort the operation in progress and restart from REQ-024 after release.
REQ-029 SHALL not reset array contents directly; only the CLEAR state zeroes them.

Structure
REQ-030 SHALL place the state enum (CLEAR, RUN) and the lane-mask and shift function in a shared package mem_pkg.
REQ-031 SHALL implement the SWL/SWR/full mask-and-data generator as the combinational sub-module store_merge; the array, FSM and read register stay in data_memory.

Verification
REQ-032 SHALL test reset then idle: Ready=0 for exactly 256 cycles, then 1; a read of 0x0040 returns 00000000.
REQ-033 SHALL test a store of 11223344 to 0x0010 followed by SWL WriteData=AABBCCDD at 0x0011, then a read of 0x0010: returns 11AABBCC.
REQ-034 SHALL test a store of 11223344 to 0x0020 followed by SWR WriteData=AABBCCDD at 0x0021, then a read: returns CCDD3344.
REQ-035 SHALL test simultaneous WriteEn=1 and WriteL=1 with data 0000FFFF at 0x0004: AccessErr pulses once; a read returns 0000FFFF.
REQ-036 SHALL test wrap-around with DEPTH=256: a store of DEADBEEF to 0x0400 is read back at 0x0000; ReadEn and WriteEn in the same cycle return DEADBEEF.
REQ-037 SHALL test reset pulsed at CLEAR cycle 100: Ready stays 0 for a further 256 cycles after release.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the word-addressed data memory.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package mem_pkg;

   // Memory sequencer: zero-fill after reset, then serve requests
   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } memState_t;

   // Which store flavour won arbitration this cycle
   typedef enum logic [1:0] {
      STORE_NONE  = 2'd0,
      STORE_FULL  = 2'd1,
      STORE_LEFT  = 2'd2,
      STORE_RIGHT = 2'd3
   } storeKind_t;

   // Bit mask of the lanes a store touches; byte 0 is the most significant byte.
   // SWR shifts by 3-b bytes, and for a 2-bit offset 3-b is simply ~b.
   function automatic logic [31:0] laneMask(input storeKind_t kind, input logic [1:0] b);
      logic [31:0] ones;
      ones = 32'hFFFF_FFFF;
      case (kind)
         STORE_FULL:  laneMask = ones;
         STORE_LEFT:  laneMask = ones >> {b, 3'b000};
         STORE_RIGHT: laneMask = ones << {~b, 3'b000};
         default:     laneMask = 32'h0000_0000;
      endcase
   endfunction

   // Store data aligned to the lanes selected by laneMask
   function automatic logic [31:0] laneShift(input storeKind_t kind, input logic [1:0] b,
                                             input logic [31:0] data);
      case (kind)
         STORE_FULL:  laneShift = data;
         STORE_LEFT:  laneShift = data >> {b, 3'b000};
         STORE_RIGHT: laneShift = data << {~b, 3'b000};
         default:     laneShift = 32'h0000_0000;
      endcase
   endfunction

endpackage

// File: rtl/store_merge.sv
// Arbitrates store strobes and merges the winning store into the current word.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the result is committed.
module store_merge
   import mem_pkg::*;
(
   input  logic        writeEn,
   input  logic        writeL,
   input  logic        writeR,
   input  logic [1:0]  byteOff,
   input  logic [31:0] writeData,
   input  logic [31:0] oldWord,
   output logic [31:0] newWord,
   output logic        storeEn,
   output logic        conflict
);

   storeKind_t  kind;
   logic [31:0] mask;
   logic [31:0] data;

   // Priority full word > SWL > SWR, then merge only the masked lanes
   always_comb begin
      kind = STORE_NONE;
      if (writeEn) begin
         kind = STORE_FULL;
      end else if (writeL) begin
         kind = STORE_LEFT;
      end else if (writeR) begin
         kind = STORE_RIGHT;
      end
      mask    = laneMask(kind, byteOff);
      data    = laneShift(kind, byteOff, writeData);
      newWord = (oldWord & ~mask) | (data & mask);
   end

   assign storeEn  = writeEn | writeL | writeR;
   assign conflict = (writeEn & writeL) | (writeEn & writeR) | (writeL & writeR);

endmodule

// File: rtl/data_memory.sv
// Single-port word memory with full, store-word-left and store-word-right writes.
// Latency: loads return one cycle after acceptance; stores commit on the accepting edge.
// Backpressure: Ready low during the post-reset zero fill; requests then are dropped.
module data_memory
   import mem_pkg::*;
#(
   parameter int DEPTH          = 256,
   parameter bit CLEAR_ON_RESET = 1'b1
)
(
   input  logic        Clock,
   input  logic        nReset,
   input  logic [15:0] Address,
   input  logic        ReadEn,
   input  logic        WriteEn,
   input  logic        WriteL,
   input  logic        WriteR,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Ready,
   output logic        AccessErr
);

   localparam int AW = $clog2(DEPTH);

   memState_t     state;
   logic [AW-1:0] clrCnt;
   logic [31:0]   mem [DEPTH];

   logic [AW-1:0] wordIdx;
   logic [1:0]    byteOff;
   logic [31:0]   oldWord;
   logic [31:0]   newWord;
   logic          storeEn;
   logic          conflict;
   logic          accept;
   logic          memWe;
   logic [AW-1:0] memIdx;
   logic [31:0]   memWdata;
   logic [15:0]   unusedAddress;

   // Upper address bits fold onto the array (wrap-around), so they are deliberately dropped
   assign unusedAddress = Address;
   assign wordIdx       = Address[AW+1:2];
   assign byteOff       = Address[1:0];
   assign oldWord       = mem[wordIdx];
   assign accept        = Ready;

   store_merge uMerge (
      .writeEn   (WriteEn),
      .writeL    (WriteL),
      .writeR    (WriteR),
      .byteOff   (byteOff),
      .writeData (WriteData),
      .oldWord   (oldWord),
      .newWord   (newWord),
      .storeEn   (storeEn),
      .conflict  (conflict)
   );

   // Single write port shared by the zero fill and accepted stores; idle while in reset
   always_comb begin
      memWe    = 1'b0;
      memIdx   = wordIdx;
      memWdata = newWord;
      if (nReset) begin
         if (state == CLEAR) begin
            memWe    = 1'b1;
            memIdx   = clrCnt;
            memWdata = 32'h0000_0000;
         end else if (accept && storeEn) begin
            memWe = 1'b1;
         end
      end
   end

   // Array storage has no reset; only the CLEAR sweep zeroes it
   always_ff @(posedge Clock) begin
      if (memWe) begin
         mem[memIdx] <= memWdata;
      end
   end

   // Sequencer, load register and conflict pulse; loads see the merged word (write-first)
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state     <= CLEAR_ON_RESET ? CLEAR : RUN;
         clrCnt    <= '0;
         Ready     <= 1'b0;
         ReadData  <= 32'h0000_0000;
         AccessErr <= 1'b0;
      end else begin
         AccessErr <= 1'b0;
         case (state)
            CLEAR: begin
               if (clrCnt == AW'(DEPTH - 1)) begin
                  state  <= RUN;
                  Ready  <= 1'b1;
                  clrCnt <= '0;
               end else begin
                  clrCnt <= clrCnt + AW'(1);
               end
            end
            RUN: begin
               Ready <= 1'b1;
               if (accept) begin
                  AccessErr <= conflict;
                  if (ReadEn) begin
                     ReadData <= storeEn ? newWord : oldWord;
                  end
               end
            end
            default: begin
               state <= RUN;
               Ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
